jogo_sequencia_param: RTL and testbench



---
 rtl/jogo_sequencia_param_if.sv | 38 +++
 rtl/jogo_sequencia_param.sv | 158 +++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/jogo_sequencia_param_if.sv
// -----------------------------------------------------------------------------
// jogo_sequencia_param_if
// Player-side bundle of the sequence-memory game controller.
//   master : board/player side. Drives iniciar, modo, chaves and observes
//            the game result and the debug view.
//   slave  : the controller. Takes the player inputs and drives
//            pronto/acertou/errou/timeout and the db_* debug signals.
// Parameters: N  = switch/code width, AW = sequence index width.
// -----------------------------------------------------------------------------
interface jogo_sequencia_param_if #(
  parameter int N  = 4,
  parameter int AW = 4
);
  logic          iniciar;
  logic          modo;
  logic [N-1:0]  chaves;
  logic          pronto;
  logic          acertou;
  logic          errou;
  logic          timeout;
  logic          db_igual;
  logic [AW-1:0] db_endereco;
  logic [AW-1:0] db_rodada;
  logic [N-1:0]  db_jogada;
  logic [3:0]    db_estado;

  modport master (
    output iniciar, modo, chaves,
    input  pronto, acertou, errou, timeout,
    input  db_igual, db_endereco, db_rodada, db_jogada, db_estado
  );

  modport slave (
    input  iniciar, modo, chaves,
    output pronto, acertou, errou, timeout,
    output db_igual, db_endereco, db_rodada, db_jogada, db_estado
  );
endinterface

// File: rtl/jogo_sequencia_param.sv
// -----------------------------------------------------------------------------
// jogo_sequencia_param
// Sequence-memory game controller. Holds a DEPTH-entry sequence of one-hot
// N-bit codes in a parameter ROM. Each rising edge of |chaves seen while
// waiting is one player move, and the move is checked against the current entry.
// In progressive mode round r requires entries 0..r. Otherwise the whole
// sequence is played once. A move that takes TIMEOUT cycles ends the game.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous active-low reset
//   bus   : jogo_sequencia_param_if.slave. The player inputs come in on
//           iniciar/modo/chaves. The Moore result flags and db_* debug view
//           go out on the same bundle.
// -----------------------------------------------------------------------------
module jogo_sequencia_param #(
  parameter int                 N       = 4,
  parameter int                 DEPTH   = 16,
  parameter int                 TIMEOUT = 5000,
  parameter logic [DEPTH*N-1:0] SEQ     = 64'h8421842184218421
) (
  input  logic                   clock,
  input  logic                   reset,
  jogo_sequencia_param_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_INICIAL     = 4'h0,
    S_PREPARA     = 4'h1,
    S_ESPERA      = 4'h2,
    S_REGISTRA    = 4'h3,
    S_COMPARA     = 4'h4,
    S_PROXIMO     = 4'h5,
    S_PROX_RODADA = 4'h6,
    S_FIM_ACERTO  = 4'hA,
    S_FIM_TIMEOUT = 4'hD,
    S_FIM_ERRO    = 4'hE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] endereco_q, endereco_d;
  logic [AW-1:0] rodada_q, rodada_d;
  logic [N-1:0]  jogada_q, jogada_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0]  chaves_prev_q;

  logic [N-1:0]  rom_entry;
  logic          igual;
  logic          move;

  // Entry under the current index. An exact compare also rejects zero and
  // multi-hot moves, because the stored codes are one-hot.
  assign rom_entry = SEQ[int'(endereco_q)*N +: N];
  assign igual     = (jogada_q == rom_entry);

  // A move is the switches leaving all-zero. Holding them, or entering
  // ESPERA with them already pressed, does not produce a move.
  assign move = (state_q == S_ESPERA) && (|bus.chaves) && !(|chaves_prev_q);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_INICIAL;
      endereco_q    <= '0;
      rodada_q      <= '0;
      jogada_q      <= '0;
      timer_q       <= '0;
      chaves_prev_q <= '0;
    end else begin
      state_q       <= state_d;
      endereco_q    <= endereco_d;
      rodada_q      <= rodada_d;
      jogada_q      <= jogada_d;
      timer_q       <= timer_d;
      chaves_prev_q <= bus.chaves;
    end
  end

  // NOTE: every output of this block gets a hold default first, so no path
  // through the case statement leaves a variable unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    jogada_d   = jogada_q;
    timer_d    = timer_q;

    unique case (state_q)
      S_INICIAL: begin
        if (bus.iniciar) state_d = S_PREPARA;
      end
      S_PREPARA: begin
        endereco_d = '0;
        jogada_d   = '0;
        timer_d    = '0;
        // rodada doubles as the latched mode. A full game is one round
        // that ends at the last index.
        rodada_d   = bus.modo ? '0 : LAST_IDX;
        state_d    = S_ESPERA;
      end
      S_ESPERA: begin
        // A move wins over a timeout that falls on the same edge.
        if (move) begin
          state_d = S_REGISTRA;
        end else if (timer_q == TMR_MAX) begin
          state_d = S_FIM_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_REGISTRA: begin
        jogada_d = bus.chaves;
        timer_d  = '0;
        state_d  = S_COMPARA;
      end
      S_COMPARA: begin
        // endereco never exceeds rodada, so "not equal" means "below".
        if (!igual)                      state_d = S_FIM_ERRO;
        else if (endereco_q != rodada_q) state_d = S_PROXIMO;
        else if (rodada_q == LAST_IDX)   state_d = S_FIM_ACERTO;
        else                             state_d = S_PROX_RODADA;
      end
      S_PROXIMO: begin
        endereco_d = endereco_q + 1'b1;
        state_d    = S_ESPERA;
      end
      S_PROX_RODADA: begin
        endereco_d = '0;
        rodada_d   = rodada_q + 1'b1;
        state_d    = S_ESPERA;
      end
      S_FIM_ACERTO, S_FIM_ERRO, S_FIM_TIMEOUT: begin
        if (bus.iniciar) state_d = S_PREPARA;
      end
      default: state_d = S_INICIAL;
    endcase
  end

  // Moore outputs decoded from the state register, so reset clears them
  // asynchronously together with the state.
  assign bus.pronto      = (state_q == S_FIM_ACERTO) || (state_q == S_FIM_ERRO) ||
                           (state_q == S_FIM_TIMEOUT);
  assign bus.acertou     = (state_q == S_FIM_ACERTO);
  assign bus.errou       = (state_q == S_FIM_ERRO) || (state_q == S_FIM_TIMEOUT);
  assign bus.timeout     = (state_q == S_FIM_TIMEOUT);
  assign bus.db_igual    = igual;
  assign bus.db_endereco = endereco_q;
  assign bus.db_rodada   = rodada_q;
  assign bus.db_jogada   = jogada_q;
  assign bus.db_estado   = state_q;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// -----------------------------------------------------------------------------
// tb_jogo_sequencia_param
// Directed bench for jogo_sequencia_param with DEPTH=4, TIMEOUT=20 and the
// sequence 1,2,4,8. It covers full and progressive games, a wrong move,
// a multi-hot move, a held switch, timeout and its last-cycle rescue,
// reset mid-game and restart.
// -----------------------------------------------------------------------------
module tb_jogo_sequencia_param;

  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;
  localparam int AW      = 2;

  // Expected state codes, written out by hand.
  localparam logic [3:0] ST_INI = 4'h0, ST_PREP = 4'h1, ST_ESP = 4'h2,
                         ST_REG = 4'h3, ST_CMP  = 4'h4, ST_PROX = 4'h5,
                         ST_PRR = 4'h6, ST_ACE  = 4'hA, ST_TMO  = 4'hD,
                         ST_ERR = 4'hE;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  jogo_sequencia_param_if #(.N(N), .AW(AW)) bus ();

  jogo_sequencia_param #(
    .N       (N),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .SEQ     (16'h8421)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_fim(input logic [3:0] s);
    return (s == ST_ACE) || (s == ST_ERR) || (s == ST_TMO);
  endfunction

  // Pulse iniciar from INICIAL or a FIM state. The game ends up in ESPERA
  // with the counters cleared.
  task automatic start_game(input logic m);
    bus.modo    = m;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    check("prepara", bus.db_estado, ST_PREP);
    step();
    check("espera", bus.db_estado, ST_ESP);
    check("clr_end", bus.db_endereco, 0);
    check("clr_jog", bus.db_jogada, 0);
    check("rodada0", bus.db_rodada, m ? 0 : DEPTH - 1);
  endtask

  // Hold code for 3 cycles, then release it for 2. The state is checked
  // on each cycle.
  task automatic do_move(input logic [3:0] code, input logic [3:0] res);
    bus.chaves = code;
    step();
    check("registra", bus.db_estado, ST_REG);
    step();
    check("compara", bus.db_estado, ST_CMP);
    check("jogada", bus.db_jogada, code);
    check("igual", bus.db_igual, res != ST_ERR);
    step();
    check("result", bus.db_estado, res);
    bus.chaves = '0;
    step();
    step();
    check("settle", bus.db_estado, is_fim(res) ? res : ST_ESP);
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    // exp = {pronto, acertou, errou, timeout}
    check(tag, {bus.pronto, bus.acertou, bus.errou, bus.timeout}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.iniciar = 1'b0;
    bus.modo    = 1'b0;
    bus.chaves  = '0;
    #3;
    check("rst_estado", bus.db_estado, ST_INI);
    check_flags("rst_flags", 4'b0000);
    check("rst_igual", bus.db_igual, 0);
    check("rst_end", bus.db_endereco, 0);
    #9 rst_n = 1'b1;
    step();
    check("idle", bus.db_estado, ST_INI);

    // Full game, all moves correct.
    start_game(1'b0);
    do_move(4'b0001, ST_PROX);
    do_move(4'b0010, ST_PROX);
    do_move(4'b0100, ST_PROX);
    do_move(4'b1000, ST_ACE);
    check_flags("ace_flags", 4'b1100);
    check("ace_end", bus.db_endereco, 3);
    check("ace_igual", bus.db_igual, 1);

    // Full game, third move wrong.
    start_game(1'b0);
    do_move(4'b0001, ST_PROX);
    do_move(4'b0010, ST_PROX);
    do_move(4'b1000, ST_ERR);
    check_flags("err_flags", 4'b1010);
    check("err_end", bus.db_endereco, 2);
    check("err_igual", bus.db_igual, 0);

    // Progressive rounds: 1 / 1,2 / 1,2,4 / 1,2,4,8.
    start_game(1'b1);
    bus.modo = 1'b0;  // modo is only sampled in PREPARA
    do_move(4'b0001, ST_PRR);
    check("rod1", bus.db_rodada, 1);
    do_move(4'b0001, ST_PROX);
    do_move(4'b0010, ST_PRR);
    check("rod2", bus.db_rodada, 2);
    do_move(4'b0001, ST_PROX);
    do_move(4'b0010, ST_PROX);
    do_move(4'b0100, ST_PRR);
    check("rod3", bus.db_rodada, 3);
    do_move(4'b0001, ST_PROX);
    do_move(4'b0010, ST_PROX);
    do_move(4'b0100, ST_PROX);
    do_move(4'b1000, ST_ACE);
    check_flags("prog_flags", 4'b1100);
    check("prog_rod", bus.db_rodada, 3);

    // No move: the 20th edge spent in ESPERA ends the game.
    start_game(1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("tmo_wait", bus.db_estado, ST_ESP);
    step();
    check("tmo_state", bus.db_estado, ST_TMO);
    check_flags("tmo_flags", 4'b1011);

    // A move on that same last edge wins over the timeout.
    start_game(1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    do_move(4'b0001, ST_PROX);
    do_move(4'b1000, ST_ERR);

    // Multi-hot code never matches.
    start_game(1'b0);
    do_move(4'b0011, ST_ERR);
    check("mh_end", bus.db_endereco, 0);

    // Holding 0001 for 10 cycles is a single move.
    start_game(1'b0);
    bus.chaves = 4'b0001;
    for (int i = 0; i < 10; i++) step();
    check("hold_state", bus.db_estado, ST_ESP);
    check("hold_end", bus.db_endereco, 1);
    bus.chaves = '0;
    step();
    step();
    do_move(4'b0010, ST_PROX);
    check("hold_end2", bus.db_endereco, 2);

    // Reset asserted while in COMPARA.
    bus.chaves = 4'b0100;
    step();
    step();
    check("pre_rst", bus.db_estado, ST_CMP);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", bus.db_estado, ST_INI);
    check("async_end", bus.db_endereco, 0);
    check_flags("async_flags", 4'b0000);
    #1 rst_n = 1'b1;
    bus.chaves = '0;
    step();
    check("post_rst", bus.db_estado, ST_INI);

    // Restart from FIM_ERRO clears the counters.
    start_game(1'b0);
    do_move(4'b0001, ST_PROX);
    do_move(4'b0100, ST_ERR);
    check("pre_restart_end", bus.db_endereco, 1);
    start_game(1'b0);
    check_flags("restart_flags", 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
